// File: rtl/add_vec_unit.sv
// Multi-lane pipelined add/subtract unit with wrap or saturate per beat.
// Valid/ready on both sides; stage 0 holds the arithmetic result, later stages are plain registers.
module add_vec_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 4,
    parameter int unsigned SIGNED = 1,
    parameter int unsigned PIPE   = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_mode,
    input  logic [LANES*DATA_W-1:0]   in_a,
    input  logic [LANES*DATA_W-1:0]   in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [LANES-1:0]          out_ovf,
    output logic [CNT_W-1:0]          ovf_cnt
);

    localparam int unsigned VEC_W     = LANES * DATA_W;
    localparam bit          IS_SIGNED = (SIGNED != 0);

    logic [PIPE-1:0]            v_q,    v_d;
    logic [PIPE-1:0][VEC_W-1:0] data_q, data_d;
    logic [PIPE-1:0][LANES-1:0] ovf_q,  ovf_d;
    logic [CNT_W-1:0]           cnt_q,  cnt_d;

    logic [VEC_W-1:0] res_c;
    logic [LANES-1:0] lane_ovf_c;
    logic [PIPE-1:0]  rdy_c;

    // Per-lane arithmetic in DATA_W+1 bits; bit DATA_W is carry-out or borrow.
    always_comb begin : lane_arith
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W:0]   r;
        logic              ovf;
        logic [DATA_W-1:0] sat_val;
        res_c      = '0;
        lane_ovf_c = '0;
        a          = '0;
        b          = '0;
        r          = '0;
        ovf        = 1'b0;
        sat_val    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            a = in_a[i*DATA_W +: DATA_W];
            b = in_b[i*DATA_W +: DATA_W];
            r = in_mode[1] ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
            if (IS_SIGNED) begin
                ovf = (in_mode[1] ? (a[DATA_W-1] != b[DATA_W-1]) : (a[DATA_W-1] == b[DATA_W-1]))
                      && (r[DATA_W-1] != a[DATA_W-1]);
                sat_val = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                ovf     = r[DATA_W];
                sat_val = in_mode[1] ? '0 : '1;
            end
            res_c[i*DATA_W +: DATA_W] = (in_mode[0] && ovf) ? sat_val : r[DATA_W-1:0];
            lane_ovf_c[i]             = ovf;
        end
    end

    // Stage k can load when the consumer pops or any stage from k to the tail has a hole.
    always_comb begin : ready_chain
        logic all_full;
        rdy_c    = '0;
        all_full = 1'b1;
        for (int k = int'(PIPE) - 1; k >= 0; k--) begin
            all_full = all_full && v_q[k];
            rdy_c[k] = out_ready || !all_full;
        end
    end

    assign in_ready = rdy_c[0] && !clr;

    always_comb begin : pipe_next
        v_d    = v_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        if (clr) begin
            v_d   = '0;
            cnt_d = '0;
        end else begin
            if (rdy_c[0]) begin
                v_d[0] = in_valid;
                if (in_valid) begin
                    data_d[0] = res_c;
                    ovf_d[0]  = lane_ovf_c;
                end
            end
            for (int unsigned k = 1; k < PIPE; k++) begin
                if (rdy_c[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        data_d[k] = data_q[k-1];
                        ovf_d[k]  = ovf_q[k-1];
                    end
                end
            end
            if (out_valid && out_ready && (|out_ovf) && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            data_q <= '0;
            ovf_q  <= '0;
            cnt_q  <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = v_q[PIPE-1];
    assign out_data  = data_q[PIPE-1];
    assign out_ovf   = ovf_q[PIPE-1];
    assign ovf_cnt   = cnt_q;

endmodule
